// File: rtl/noc_host_injector_if.sv
// Host and network-side signal bundle for noc_host_injector.
// master is the host/router side, slave is the injector itself.
interface noc_host_injector_if #(
  parameter int PACKET_SIZE = 8
);
  logic [PACKET_SIZE-1:0] host_data_in;
  logic                   host_enable_in;
  logic                   host_full;
  logic [PACKET_SIZE-1:0] net_data_out;
  logic                   net_enable_out;
  logic                   net_buffer_full;
  logic [PACKET_SIZE-1:0] loop_data_out;
  logic                   loop_valid_out;
  logic [15:0]            sent_count;
  logic [7:0]             drop_count;

  modport master (
    output host_data_in, host_enable_in, net_buffer_full,
    input  host_full, net_data_out, net_enable_out,
    input  loop_data_out, loop_valid_out, sent_count, drop_count
  );

  modport slave (
    input  host_data_in, host_enable_in, net_buffer_full,
    output host_full, net_data_out, net_enable_out,
    output loop_data_out, loop_valid_out, sent_count, drop_count
  );
endinterface

// File: rtl/noc_host_injector.sv
// Host network interface: queues host packets and injects them one flit
// at a time into a ring router port, looping self-addressed packets back.
module noc_host_injector #(
  parameter int ROUTER_ID   = 0,
  parameter int PACKET_SIZE = 8,
  parameter int ROUTER_BITS = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int INJECT_GAP  = 2
) (
  input logic               clk,
  input logic               rst,
  noc_host_injector_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, GAP, SEND} state_e;

  logic [PACKET_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [AW-1:0]          rptr_q, rptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  state_e                 state_q, state_d;
  logic [3:0]             gap_q, gap_d;
  logic [PACKET_SIZE-1:0] ndata_q, ndata_d;
  logic                   nen_q, nen_d;
  logic [PACKET_SIZE-1:0] ldata_q, ldata_d;
  logic                   lval_q, lval_d;
  logic [15:0]            sent_q, sent_d;
  logic [7:0]             drop_q, drop_d;

  logic full_w, self_w, push_w, drop_w, pop_w;

  assign full_w = (cnt_q == CW'(FIFO_DEPTH));
  assign self_w = bus.host_enable_in &&
    (bus.host_data_in[ROUTER_BITS-1:0] == ROUTER_BITS'(ROUTER_ID));
  assign push_w = bus.host_enable_in && !self_w && !full_w;
  assign drop_w = bus.host_enable_in && !self_w && full_w;
  // full flag is only consulted while not in the post-flit gap
  assign pop_w  = (state_q != GAP) && (cnt_q != '0) &&
    !bus.net_buffer_full;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    nen_d   = 1'b0;
    ndata_d = '0;
    sent_d  = sent_q;
    unique case (state_q)
      IDLE, SEND: begin
        if (pop_w) begin
          nen_d   = 1'b1;
          ndata_d = mem_q[rptr_q];
          sent_d  = sent_q + 16'd1;
          if (INJECT_GAP == 0) begin
            state_d = SEND;
          end else begin
            state_d = GAP;
            gap_d   = 4'(INJECT_GAP);
          end
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d = push_w ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop_w ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    if (push_w && !pop_w) cnt_d = cnt_q + 1'b1;
    else if (!push_w && pop_w) cnt_d = cnt_q - 1'b1;
    lval_d  = self_w;
    ldata_d = self_w ? bus.host_data_in : ldata_q;
    drop_d  = (drop_w && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (push_w) mem_q[wptr_q] <= bus.host_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      gap_q   <= '0;
      ndata_q <= '0;
      nen_q   <= 1'b0;
      ldata_q <= '0;
      lval_q  <= 1'b0;
      sent_q  <= '0;
      drop_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      gap_q   <= gap_d;
      ndata_q <= ndata_d;
      nen_q   <= nen_d;
      ldata_q <= ldata_d;
      lval_q  <= lval_d;
      sent_q  <= sent_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.host_full      = full_w;
  assign bus.net_data_out   = ndata_q;
  assign bus.net_enable_out = nen_q;
  assign bus.loop_data_out  = ldata_q;
  assign bus.loop_valid_out = lval_q;
  assign bus.sent_count     = sent_q;
  assign bus.drop_count     = drop_q;
endmodule

// File: tb/tb_noc_host_injector.sv
// Scoreboard bench for noc_host_injector: instance A (id 0, gap 2)
// and instance B (id 2, gap 0) driven by directed vectors.
module tb_noc_host_injector;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  noc_host_injector_if #(.PACKET_SIZE(8)) ia ();
  noc_host_injector_if #(.PACKET_SIZE(8)) ib ();

  noc_host_injector #(
    .ROUTER_ID(0), .PACKET_SIZE(8), .ROUTER_BITS(2),
    .FIFO_DEPTH(4), .INJECT_GAP(2)
  ) ua (.clk(clk), .rst(rst_a), .bus(ia.slave));

  noc_host_injector #(
    .ROUTER_ID(2), .PACKET_SIZE(8), .ROUTER_BITS(2),
    .FIFO_DEPTH(4), .INJECT_GAP(0)
  ) ub (.clk(clk), .rst(rst_b), .bus(ib.slave));

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qb_loop[$];
  int         pa_cyc[$];
  int         pb_cyc[$];
  logic       prev_en_a = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor A
  always @(negedge clk) begin
    if (ia.net_enable_out) begin
      pa_cyc.push_back(cyc);
      chk("A no back-to-back", 32'(prev_en_a), 32'd0);
      if (qa.size() == 0) chk("A unexpected flit", 32'(ia.net_data_out), 32'hFFFF);
      else chk("A flit data", 32'(ia.net_data_out), 32'(qa.pop_front()));
    end
    if (ia.loop_valid_out) chk("A unexpected loop", 32'd1, 32'd0);
    prev_en_a = ia.net_enable_out;
  end

  // Monitor B
  always @(negedge clk) begin
    if (ib.net_enable_out) begin
      pb_cyc.push_back(cyc);
      if (qb.size() == 0) chk("B unexpected flit", 32'(ib.net_data_out), 32'hFFFF);
      else chk("B flit data", 32'(ib.net_data_out), 32'(qb.pop_front()));
    end
    if (ib.loop_valid_out) begin
      if (qb_loop.size() == 0) chk("B unexpected loop", 32'(ib.loop_data_out), 32'hFFFF);
      else chk("B loop data", 32'(ib.loop_data_out), 32'(qb_loop.pop_front()));
    end
  end

  task automatic wr_a(input logic [7:0] d, input bit expect_q);
    ia.host_data_in = d;
    ia.host_enable_in = 1'b1;
    if (expect_q) qa.push_back(d);
    step(1);
    ia.host_enable_in = 1'b0;
  endtask

  task automatic wr_b(input logic [7:0] d);
    ib.host_data_in = d;
    ib.host_enable_in = 1'b1;
    if (d[1:0] == 2'd2) qb_loop.push_back(d);
    else qb.push_back(d);
    step(1);
    ib.host_enable_in = 1'b0;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    step(2);
    rst_a = 1'b0;
    qa.delete();
  endtask

  initial begin
    int base;
    logic [7:0] v3 [4];
    logic [7:0] v6a [4];
    logic [7:0] v6b [4];
    v3  = '{8'h41, 8'h42, 8'h43, 8'h45};
    v6a = '{8'h91, 8'h93, 8'h94, 8'h95};
    v6b = '{8'hA1, 8'hA3, 8'hA4, 8'hA5};
    rst_a = 1'b1; rst_b = 1'b1;
    ia.host_data_in = '0; ia.host_enable_in = 1'b0; ia.net_buffer_full = 1'b0;
    ib.host_data_in = '0; ib.host_enable_in = 1'b0; ib.net_buffer_full = 1'b0;
    step(3);
    rst_a = 1'b0; rst_b = 1'b0;
    chk("rst en", 32'(ia.net_enable_out), 32'd0);
    chk("rst data", 32'(ia.net_data_out), 32'd0);
    chk("rst loop", 32'(ia.loop_valid_out), 32'd0);
    chk("rst sent", 32'(ia.sent_count), 32'd0);
    chk("rst drop", 32'(ia.drop_count), 32'd0);
    chk("rst full", 32'(ia.host_full), 32'd0);
    step(1);

    // 1: single packet latency and gap
    wr_a(8'h05, 1'b1);
    chk("t1 en after push", 32'(ia.net_enable_out), 32'd0);
    step(1);
    chk("t1 en issue", 32'(ia.net_enable_out), 32'd1);
    chk("t1 data issue", 32'(ia.net_data_out), 32'h05);
    chk("t1 sent", 32'(ia.sent_count), 32'd1);
    step(1);
    chk("t1 gap1", 32'(ia.net_enable_out), 32'd0);
    step(1);
    chk("t1 gap2", 32'(ia.net_enable_out), 32'd0);
    step(4);

    // 2: three packets, 3-cycle pulse spacing
    base = pa_cyc.size();
    wr_a(8'h11, 1'b1);
    chk("t2 full", 32'(ia.host_full), 32'd0);
    wr_a(8'h22, 1'b1);
    chk("t2 full", 32'(ia.host_full), 32'd0);
    wr_a(8'h33, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t2 full", 32'(ia.host_full), 32'd0);
      step(1);
    end
    chk("t2 pulses", 32'(pa_cyc.size() - base), 32'd3);
    if (pa_cyc.size() - base == 3) begin
      chk("t2 spacing1", 32'(pa_cyc[base+1] - pa_cyc[base]), 32'd3);
      chk("t2 spacing2", 32'(pa_cyc[base+2] - pa_cyc[base+1]), 32'd3);
    end

    // 3: backpressure, fill, drop, drain
    reset_a();
    ia.net_buffer_full = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) begin
      wr_a(v3[i], 1'b1);
      chk("t3 full", 32'(ia.host_full), (i == 3) ? 32'd1 : 32'd0);
    end
    wr_a(8'h46, 1'b0);
    chk("t3 drop", 32'(ia.drop_count), 32'd1);
    chk("t3 full held", 32'(ia.host_full), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t3 no issue", 32'(ia.net_enable_out), 32'd0);
      step(1);
    end
    ia.net_buffer_full = 1'b0;
    step(13);
    chk("t3 sent", 32'(ia.sent_count), 32'd4);
    chk("t3 drained", 32'(ia.host_full), 32'd0);
    chk("t3 queue", 32'(qa.size()), 32'd0);

    // 5: reset during GAP flushes the FIFO
    reset_a();
    step(1);
    wr_a(8'h51, 1'b1);
    wr_a(8'h52, 1'b1);
    wr_a(8'h53, 1'b1);
    rst_a = 1'b1;
    step(1);
    chk("t5 en", 32'(ia.net_enable_out), 32'd0);
    chk("t5 data", 32'(ia.net_data_out), 32'd0);
    chk("t5 sent", 32'(ia.sent_count), 32'd0);
    chk("t5 full", 32'(ia.host_full), 32'd0);
    rst_a = 1'b0;
    qa.delete();
    base = pa_cyc.size();
    step(10);
    chk("t5 no flits", 32'(pa_cyc.size() - base), 32'd0);
    chk("t5 sent after", 32'(ia.sent_count), 32'd0);

    // 4: loopback on B while FIFO full
    rst_b = 1'b1;
    step(2);
    rst_b = 1'b0;
    ib.net_buffer_full = 1'b1;
    wr_b(8'h81);
    wr_b(8'h83);
    wr_b(8'h84);
    wr_b(8'h85);
    chk("t4 full", 32'(ib.host_full), 32'd1);
    wr_b(8'h0E);
    chk("t4 loop valid", 32'(ib.loop_valid_out), 32'd1);
    chk("t4 loop data", 32'(ib.loop_data_out), 32'h0E);
    chk("t4 drop", 32'(ib.drop_count), 32'd0);
    chk("t4 full kept", 32'(ib.host_full), 32'd1);
    step(1);
    chk("t4 loop pulse", 32'(ib.loop_valid_out), 32'd0);
    ib.net_buffer_full = 1'b0;
    step(6);
    chk("t4 sent", 32'(ib.sent_count), 32'd4);

    // 6a: gap 0, back-to-back flits
    base = pb_cyc.size();
    for (int i = 0; i < 4; i++) wr_b(v6a[i]);
    step(4);
    chk("t6 pulses", 32'(pb_cyc.size() - base), 32'd4);
    if (pb_cyc.size() - base == 4)
      chk("t6 consecutive", 32'(pb_cyc[base+3] - pb_cyc[base]), 32'd3);
    chk("t6 sent", 32'(ib.sent_count), 32'd8);

    // 6b: stall before third issue edge, then resume
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ib.net_buffer_full = 1'b1;
      wr_b(v6b[i]);
    end
    for (int i = 0; i < 4; i++) begin
      chk("t6 paused", 32'(ib.net_enable_out), 32'd0);
      step(1);
    end
    chk("t6 sent paused", 32'(ib.sent_count), 32'd10);
    ib.net_buffer_full = 1'b0;
    step(5);
    chk("t6 sent resumed", 32'(ib.sent_count), 32'd12);

    chk("end qa", 32'(qa.size()), 32'd0);
    chk("end qb", 32'(qb.size()), 32'd0);
    chk("end qb_loop", 32'(qb_loop.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/noc_host_injector.md
Name: noc_host_injector

Overview:
Host-side network interface that sits directly upstream of a ring router's input port. It queues 8-bit packets from the local host in a small FIFO and injects them one flit at a time into the router port using the router's enable/buffer_full handshake. Packets addressed to the local router are looped back to the host and never enter the network. A mandatory idle gap follows each injected flit so that the router's registered buffer_full flag has time to update.

Parameters:
ROUTER_ID, 0, ID of the attached router; compared against the packet destination field.
PACKET_SIZE, 8, packet width in bits.
ROUTER_BITS, 2, width of the destination field, located at packet bits [ROUTER_BITS-1:0].
FIFO_DEPTH, 4, number of host packet entries; must be a power of two and at least 2.
INJECT_GAP, 2, number of idle cycles forced after each injected flit; range 0..15.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
host_data_in  input  PACKET_SIZE  packet from the host.
host_enable_in  input  1  host write strobe; one packet per cycle.
host_full  output  1  FIFO full; the host must not write while this is high.
net_data_out  output  PACKET_SIZE  flit driven into the router input data port.
net_enable_out  output  1  single-cycle flit-valid pulse into the router input enable.
net_buffer_full  input  1  router indicates it has no free VC.
loop_data_out  output  PACKET_SIZE  self-addressed packet returned to the host.
loop_valid_out  output  1  one-cycle pulse qualifying loop_data_out.
sent_count  output  16  number of flits injected; wraps modulo 2^16.
drop_count  output  8  number of host writes refused because the FIFO was full; saturates at 255.

Behaviour:
- Reset (synchronous): the following all go to 0: FIFO read/write pointers and occupancy, state (IDLE), gap counter, net_data_out, net_enable_out, loop_data_out, loop_valid_out, sent_count, drop_count.
- Reset applied mid-operation flushes all queued packets. If a flit is in flight, net_enable_out is 0 on the cycle after the reset edge.
- host_full is combinational: (occupancy == FIFO_DEPTH), decoded from registered occupancy only.
- Host write (host_enable_in = 1):
  - Self-addressed, i.e. host_data_in[ROUTER_BITS-1:0] == ROUTER_ID: the packet is not queued. On the next cycle, loop_data_out = packet and loop_valid_out = 1. This path is accepted even when the FIFO is full.
  - Otherwise, if the FIFO is not full: push the packet.
  - Otherwise (FIFO full): the write is discarded and drop_count increments, saturating.
- loop_valid_out is 0 in every cycle that does not follow a self-addressed write. loop_data_out holds its last value.
- FIFO pointers wrap modulo FIFO_DEPTH.
- A push and a pop in the same cycle leave occupancy unchanged.
- A write while full is refused even if a pop occurs in the same cycle (no write-through).
- The FSM updates only on the rising edge. It has three states:
  - IDLE:
    - Condition: occupancy > 0 and net_buffer_full == 0.
    - Action: net_data_out <= FIFO head; net_enable_out <= 1; pop the FIFO; sent_count++.
    - Next state: GAP with gap counter = INJECT_GAP, or SEND if INJECT_GAP == 0.
    - Otherwise: net_enable_out <= 0 and net_data_out <= 0.
  - GAP:
    - Action: net_enable_out <= 0 and net_data_out <= 0; gap counter decrements.
    - Exit: when the counter is 1 on entry to the cycle, go to IDLE.
    - Result: exactly INJECT_GAP low cycles between flits.
  - SEND (used only when INJECT_GAP == 0): behaves exactly like IDLE.
    - Result: back-to-back flits are allowed, one per cycle, while net_buffer_full stays low.
- Timing and latency:
  - A packet written into an empty FIFO with net_buffer_full low appears as net_enable_out = 1 two edges later: push at edge N, issue at edge N+1.
  - net_enable_out is never high for two consecutive cycles when INJECT_GAP >= 1.
- net_buffer_full is sampled only in IDLE/SEND. Its assertion during GAP has no effect until the FSM returns to IDLE.
- A flit already issued (net_enable_out high) is never retracted. The downstream router is responsible for accepting any flit presented while its sampled full flag was low.
- Ordering: flits leave in host write order. Loop-back packets bypass the FIFO and may overtake earlier queued packets.
- The module never drives X or Z. Idle data is 0.

Test Plan:
1. Reset, then write 0x05 (dest 1) with ROUTER_ID = 0 and net_buffer_full = 0. Required: net_enable_out = 1 with net_data_out = 0x05 two edges after the write, for exactly one cycle; sent_count = 1; then 2 low cycles.
2. Write 0x11, 0x22, 0x33 on consecutive cycles (INJECT_GAP = 2). Required: three enable pulses in order 0x11, 0x22, 0x33, spaced 3 cycles apart; host_full never asserts.
3. Hold net_buffer_full = 1 and write 5 packets with dest != 0. Required: host_full = 1 after the 4th write; the 5th is dropped with drop_count = 1; no enable pulse. Release net_buffer_full: 4 flits emerge in order, then sent_count = 4.
4. With ROUTER_ID = 2, write 0x0E (dest 2) while the FIFO is full. Required: loop_valid_out = 1 and loop_data_out = 0x0E the next cycle; drop_count unchanged; the FIFO is unaffected.
5. Load 3 packets and assert rst for one cycle during a GAP. Required: all outputs are 0 after the reset edge; no further flits emerge; sent_count = 0.
6. With INJECT_GAP = 0, load 4 packets with net_buffer_full = 0. Required: 4 consecutive enable-high cycles. Drive net_buffer_full = 1 before the 3rd issue edge: injection pauses, then resumes with the remaining flits when net_buffer_full returns to 0.
